// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: state encodings, widths and
// operand sign-conditioning helpers.
package div_unit_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned CNT_W    = 6;
   localparam int unsigned DIV_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DIVZERO = 2'd1,
      ST_BUSY    = 2'd2,
      ST_DONE    = 2'd3
   } div_state_e;

   // Magnitude of an operand; unsigned operands pass through untouched.
   function automatic logic [DATA_W-1:0] op_mag(input logic [DATA_W-1:0] v,
                                                input logic               is_signed);
      return (is_signed && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
   endfunction

   // Two's-complement negate when requested.
   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                  input logic               neg);
      return neg ? (~v + DATA_W'(1)) : v;
   endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Stalls the front of the
// pipeline while working and presents a one-cycle hi/lo write in DONE.
module div_unit
   import div_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_div,
   input  logic [31:0]       opdata1,
   input  logic [31:0]       opdata2,
   input  logic              annul,
   output logic [31:0]       result_lo,
   output logic [31:0]       result_hi,
   output logic              ready,
   output logic              hi_we,
   output logic              lo_we,
   output logic              stall_req
);

   div_state_e          state_q, state_d;
   logic [DATA_W-1:0]   rem_q, quo_q, dvs_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                q_neg_q, r_neg_q;

   logic                accept_c;
   logic                last_c;
   logic [DATA_W:0]     trial_c;
   logic [DATA_W-1:0]   step_rem_c, step_quo_c;

   assign accept_c = (state_q == ST_IDLE) && start && !annul;
   assign last_c   = (cnt_q == CNT_W'(DIV_ITER - 1));

   // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
   always_comb begin
      trial_c    = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};
      step_rem_c = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
      step_quo_c = {quo_q[DATA_W-2:0], 1'b0};
      if (!trial_c[DATA_W]) begin
         step_rem_c = trial_c[DATA_W-1:0];
         step_quo_c = {quo_q[DATA_W-2:0], 1'b1};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and pipeline stall decode.
   always_comb begin
      state_d   = state_q;
      stall_req = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall_req = accept_c;
            if (accept_c) state_d = (opdata2 == '0) ? ST_DIVZERO : ST_BUSY;
         end
         ST_DIVZERO: begin
            stall_req = 1'b1;
            state_d   = annul ? ST_IDLE : ST_DONE;
         end
         ST_BUSY: begin
            stall_req = 1'b1;
            if (annul)       state_d = ST_IDLE;
            else if (last_c) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Write strobes asserted for exactly the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready <= 1'b0;
         hi_we <= 1'b0;
         lo_we <= 1'b0;
      end else begin
         ready <= (state_d == ST_DONE);
         hi_we <= (state_d == ST_DONE);
         lo_we <= (state_d == ST_DONE);
      end
   end

   // Operand capture, iteration datapath and sign-corrected result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  rem_q   <= '0;
                  quo_q   <= op_mag(opdata1, signed_div);
                  dvs_q   <= op_mag(opdata2, signed_div);
                  cnt_q   <= '0;
                  q_neg_q <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                  r_neg_q <= signed_div && opdata1[DATA_W-1];
               end
            end
            ST_BUSY: begin
               if (!annul) begin
                  rem_q <= step_rem_c;
                  quo_q <= step_quo_c;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_c) begin
                     result_lo <= cond_neg(step_quo_c, q_neg_q);
                     result_hi <= cond_neg(step_rem_c, r_neg_q);
                  end
               end
            end
            ST_DIVZERO: begin
               if (!annul) begin
                  result_lo <= '0;
                  result_hi <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit with a transaction-level reference model.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, signed_div, annul;
   logic [31:0] opdata1, opdata2;
   logic [31:0] result_lo, result_hi;
   logic        ready, hi_we, lo_we, stall_req;

   int n_chk  = 0;
   int n_fail = 0;

   div_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .annul      (annul),
      .result_lo  (result_lo),
      .result_hi  (result_hi),
      .ready      (ready),
      .hi_we      (hi_we),
      .lo_we      (lo_we),
      .stall_req  (stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: wide signed division avoids the MIN/-1 overflow.
   function automatic void model_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = 32'd0;
         r = 32'd0;
      end else if (sd) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Transaction model: an accepted request completes 33 (or 2) cycles later unless annulled/reset.
   int          cyc     = 0;
   bit          mvalid  = 0;
   bit          pending = 0;
   int          done_at = -1;
   logic [31:0] p_lo, p_hi;
   logic [31:0] e_lo = 32'd0, e_hi = 32'd0;

   always @(posedge clk) begin
      if (rst) begin
         pending = 0;
         e_lo    = 32'd0;
         e_hi    = 32'd0;
         mvalid  = 1;
      end else if (pending) begin
         if (cyc == done_at) pending = 0;
         else if (annul)     pending = 0;
      end else if (start && !annul) begin
         pending = 1;
         done_at = cyc + ((opdata2 == 32'd0) ? 2 : 33);
         model_div(signed_div, opdata1, opdata2, p_lo, p_hi);
      end
      cyc++;
      if (pending && cyc == done_at) begin
         e_lo = p_lo;
         e_hi = p_hi;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic exp_rdy, exp_stall;
      if (mvalid) begin
         exp_rdy   = pending && (cyc == done_at);
         exp_stall = pending ? (cyc < done_at) : (start && !annul);
         chk("ready",     32'(ready),     32'(exp_rdy));
         chk("hi_we",     32'(hi_we),     32'(exp_rdy));
         chk("lo_we",     32'(lo_we),     32'(exp_rdy));
         chk("stall_req", 32'(stall_req), 32'(exp_stall));
         chk("result_lo", result_lo, e_lo);
         chk("result_hi", result_hi, e_hi);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one division, scramble the operands after acceptance, wait for ready and pin the result.
   task automatic run(input logic sd, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                      input int lat, input bit hold_done);
      int  s;
      bit  got;
      start      = 1'b1;
      signed_div = sd;
      opdata1    = a;
      opdata2    = b;
      s          = cyc;
      tick();
      start      = 1'b0;
      signed_div = ~sd;
      opdata1    = $urandom;
      opdata2    = $urandom;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (ready) got = 1;
      end
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout: no ready within 40 cycles for 0x%08h/0x%08h", a, b);
      end else begin
         chk("latency", 32'(cyc - s), 32'(lat));
         chk("lit_lo", result_lo, exp_lo);
         chk("lit_hi", result_hi, exp_hi);
         chk("lit_stall_done", 32'(stall_req), 32'd0);
      end
      if (hold_done) start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] q, r;
      int s;
      rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
      opdata1 = 32'd0; opdata2 = 32'd0;

      // Pin the reference model to hand-computed values.
      model_div(1'b0, 32'd100, 32'd7, q, r);
      chk("model_divu", q, 32'd14);          chk("model_divu_r", r, 32'd2);
      model_div(1'b1, 32'hFFFFFFF9, 32'd2, q, r);
      chk("model_div", q, 32'hFFFFFFFD);     chk("model_div_r", r, 32'hFFFFFFFF);
      model_div(1'b1, 32'h80000000, 32'hFFFFFFFF, q, r);
      chk("model_wrap", q, 32'h80000000);    chk("model_wrap_r", r, 32'd0);
      model_div(1'b0, 32'd5, 32'd0, q, r);
      chk("model_dz", q, 32'd0);             chk("model_dz_r", r, 32'd0);

      tick(); tick();
      chk("rst_lo", result_lo, 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      rst = 1'b0;
      tick();

      run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
      run(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
      run(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, 1'b0);
      run(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 2, 1'b0);
      run(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, 1'b1);
      repeat (3) tick();
      run(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 33, 1'b0);
      run(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33, 1'b0);

      // Annul in BUSY, then a fresh request two cycles later.
      start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
      s = cyc;
      tick();
      start = 1'b0;
      repeat (9) tick();
      annul = 1'b1;
      tick();
      annul = 1'b0;
      @(negedge clk);
      chk("annul_stall", 32'(stall_req), 32'd0);
      chk("annul_ready", 32'(ready), 32'd0);
      tick();
      chk("annul_cycle", 32'(cyc - s), 32'd12);
      run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);

      // Start together with annul: annul wins.
      start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
      tick();
      start = 1'b0; annul = 1'b0;
      @(negedge clk);
      chk("start_annul_stall", 32'(stall_req), 32'd0);
      tick();

      // Reset in the middle of a division.
      start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
      tick();
      start = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_lo", result_lo, 32'd0);
      chk("midrst_hi", result_hi, 32'd0);
      chk("midrst_ready", 32'(ready), 32'd0);
      chk("midrst_stall", 32'(stall_req), 32'd0);
      repeat (40) tick();
      run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
